// File: rtl/mips_pkg.sv
// Shared MIPS fetch/decode definitions: fetch FSM states, reset PC default,
// instruction width and field bit positions.
package mips_pkg;

  localparam int INSTR_W = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_MSB  = 10;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

  // Sequential PC increment; wraps modulo 2^32.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/ir_field_split.sv
// Pure combinational split of a MIPS instruction word into its fields.
// Shared between fetch and decode.
module ir_field_split
  import mips_pkg::*;
(
  input  logic [INSTR_W-1:0] i_ir,
  output logic [5:0]         o_opcode,
  output logic [4:0]         o_rs,
  output logic [4:0]         o_rt,
  output logic [4:0]         o_rd,
  output logic [4:0]         o_shamt,
  output logic [5:0]         o_funct,
  output logic [15:0]        o_imm16
);

  assign o_opcode = i_ir[OPCODE_MSB:OPCODE_LSB];
  assign o_rs     = i_ir[RS_MSB:RS_LSB];
  assign o_rt     = i_ir[RT_MSB:RT_LSB];
  assign o_rd     = i_ir[RD_MSB:RD_LSB];
  assign o_shamt  = i_ir[SHAMT_MSB:SHAMT_LSB];
  assign o_funct  = i_ir[FUNCT_MSB:FUNCT_LSB];
  assign o_imm16  = i_ir[IMM_MSB:IMM_LSB];

endmodule

// File: rtl/fetch_ir_unit.sv
// Multi-cycle fetch stage: PC, instruction-memory handshake, IR and redirect.
// Define FETCH_MISALIGN_CHK_EN to add the misalign port and trap on unaligned redirects.
module fetch_ir_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [31:0] ir_instr,
  output logic [31:0] ir_pc,
  output logic [31:0] ir_pc_plus4,
  output logic [5:0]  ir_opcode,
  output logic [4:0]  ir_rs,
  output logic [4:0]  ir_rt,
  output logic [4:0]  ir_rd,
  output logic [4:0]  ir_shamt,
  output logic [5:0]  ir_funct,
  output logic [15:0] ir_imm16
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic        misalign
`endif
);

  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_ir;
  logic [31:0]  r_ir_pc;
  logic         r_imem_req;
  logic         r_ir_valid;
  logic         w_idle_hold;

`ifdef FETCH_MISALIGN_CHK_EN
  logic         r_misalign;
  logic         w_redir_bad;
  assign w_redir_bad = (redirect_pc[1:0] != 2'b00);
  assign w_idle_hold = r_misalign;
  assign misalign    = r_misalign;
`else
  assign w_idle_hold = 1'b0;
`endif

  // Redirect overrides the normal sequence; a same-cycle ack is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_ir       <= 32'h0000_0000;
      r_ir_pc    <= 32'h0000_0000;
      r_imem_req <= 1'b0;
      r_ir_valid <= 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
      r_misalign <= 1'b0;
`endif
    end else if (redirect_valid) begin
      r_ir_valid <= 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
      r_pc       <= redirect_pc;
      r_misalign <= w_redir_bad;
      r_state    <= w_redir_bad ? S_IDLE : S_REQ;
      r_imem_req <= ~w_redir_bad;
`else
      r_pc       <= {redirect_pc[31:2], 2'b00};
      r_state    <= S_REQ;
      r_imem_req <= 1'b1;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_idle_hold) begin
            r_state    <= S_REQ;
            r_imem_req <= 1'b1;
          end
        end
        S_REQ: begin
          if (imem_ack) begin
            r_ir       <= imem_rdata;
            r_ir_pc    <= r_pc;
            r_pc       <= pc_plus4(r_pc);
            r_state    <= S_HOLD;
            r_imem_req <= 1'b0;
            r_ir_valid <= 1'b1;
          end
        end
        S_HOLD: begin
          if (r_ir_valid && ir_ready) begin
            r_state    <= S_REQ;
            r_imem_req <= 1'b1;
            r_ir_valid <= 1'b0;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_imem_req <= 1'b0;
          r_ir_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_pc;
  assign ir_valid    = r_ir_valid;
  assign ir_instr    = r_ir;
  assign ir_pc       = r_ir_pc;
  assign ir_pc_plus4 = pc_plus4(r_ir_pc);

  ir_field_split u_split (
    .i_ir     (r_ir),
    .o_opcode (ir_opcode),
    .o_rs     (ir_rs),
    .o_rt     (ir_rt),
    .o_rd     (ir_rd),
    .o_shamt  (ir_shamt),
    .o_funct  (ir_funct),
    .o_imm16  (ir_imm16)
  );

endmodule
